// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes and special register IDs.
package y86_pkg;

    typedef logic [3:0]  reg_id_t;
    typedef logic [63:0] word_t;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam reg_id_t REG_RSP  = 4'h4;
    localparam reg_id_t REG_NONE = 4'hF;
    localparam int      NUM_REGS = 15;

endpackage

// File: rtl/regfile.sv
// Fifteen 64-bit registers, two async read ports, two write ports (M beats E).
// WB_BYPASS_EN: reads return same-cycle pending write data.
module regfile
    import y86_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  reg_id_t src_a,
    input  reg_id_t src_b,
    output word_t   val_a,
    output word_t   val_b,
    input  logic    we,
    input  reg_id_t dst_e,
    input  word_t   val_e,
    input  reg_id_t dst_m,
    input  word_t   val_m
);

    word_t regs [0:NUM_REGS-1];

    // NOTE: every register here must read as zero during reset, so the array is
    // reset flop-by-flop rather than left as an unreset RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            // ID 0xF never matches an index, so writes to "none" fall away.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (dst_m == reg_id_t'(i))      regs[i] <= val_m;
                else if (dst_e == reg_id_t'(i)) regs[i] <= val_e;
            end
        end
    end

    // NOTE: defaults are assigned first so no path through always_comb leaves an
    // output unassigned, which would otherwise infer a latch.
    always_comb begin
        val_a = '0;
        val_b = '0;
        if (src_a != REG_NONE) val_a = regs[src_a];
        if (src_b != REG_NONE) val_b = regs[src_b];
`ifdef WB_BYPASS_EN
        if (we && src_a != REG_NONE) begin
            if (src_a == dst_m)      val_a = val_m;
            else if (src_a == dst_e) val_a = val_e;
        end
        if (we && src_b != REG_NONE) begin
            if (src_b == dst_m)      val_b = val_m;
            else if (src_b == dst_e) val_b = val_e;
        end
`else
`endif
    end

endmodule

// File: rtl/decode_wb.sv
// Y86-64 decode/writeback: register selectors, register file and retire counter.
// WB_BYPASS_EN (in regfile) forwards pending writeback data to the read ports.
module decode_wb
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        valid_instr,
    input  logic        halt,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] retired
);

    logic wb_ok;

    assign wb_ok = valid_instr & ~halt;

    always_comb begin
        srcA = REG_NONE;
        srcB = REG_NONE;
        dstE = REG_NONE;
        dstM = REG_NONE;
        case (icode)
            IRRMOVQ: begin
                srcA = rA;
                if (cnd) dstE = rB;
            end
            IIRMOVQ: dstE = rB;
            IRMMOVQ: begin
                srcA = rA;
                srcB = rB;
            end
            IMRMOVQ: begin
                srcB = rB;
                dstM = rA;
            end
            IOPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            ICALL: begin
                srcB = REG_RSP;
                dstE = REG_RSP;
            end
            IRET: begin
                srcA = REG_RSP;
                srcB = REG_RSP;
                dstE = REG_RSP;
            end
            IPUSHQ: begin
                srcA = rA;
                srcB = REG_RSP;
                dstE = REG_RSP;
            end
            IPOPQ: begin
                srcA = REG_RSP;
                srcB = REG_RSP;
                dstE = REG_RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .src_a (srcA),
        .src_b (srcB),
        .val_a (valA),
        .val_b (valB),
        .we    (wb_ok),
        .dst_e (dstE),
        .val_e (valE),
        .dst_m (dstM),
        .val_m (valM)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     retired <= '0;
        else if (wb_ok) retired <= retired + 64'd1;
    end

endmodule

// File: tb/tb_decode_wb.sv
// Directed self-checking bench for decode_wb with a scoreboard of expected values.
// Expectations follow WB_BYPASS_EN when it is defined for the build.
module tb_decode_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode, rA, rB;
    logic        valid_instr, halt, cnd;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, retired;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    decode_wb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .icode       (icode),
        .rA          (rA),
        .rB          (rB),
        .valid_instr (valid_instr),
        .halt        (halt),
        .cnd         (cnd),
        .valE        (valE),
        .valM        (valM),
        .srcA        (srcA),
        .srcB        (srcB),
        .dstE        (dstE),
        .dstM        (dstM),
        .valA        (valA),
        .valB        (valB),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] observed);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0h required=entry", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.exp) n_pass++;
            else $error("FAIL %s observed=%0h required=%0h", e.tag, observed, e.exp);
        end
    endtask

    task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic v, input logic h, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm);
        icode = ic; rA = ra; rB = rb;
        valid_instr = v; halt = h; cnd = c;
        valE = ve; valM = vm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read register r onto valA via an opq that is not committed.
    task automatic read_a(input logic [3:0] r);
        drive(4'h6, r, 4'hF, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'h1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();

        // Reset state; selectors stay live during reset.
        drive(4'h6, 4'h3, 4'h5, 1'b1, 1'b0, 1'b0, 64'h11, 64'h22);
        expect_v("rst_retired", 64'h0);     check(retired);
        expect_v("rst_valA", 64'h0);        check(valA);
        expect_v("rst_srcA", 64'h3);        check({60'h0, srcA});
        expect_v("rst_dstE", 64'h5);        check({60'h0, dstE});
        tick();
        expect_v("rst_hold_retired", 64'h0); check(retired);

        // Release away from the edge; first write on the next rising edge.
        #2 rst_n = 1'b1;
        drive(4'h3, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0, 64'h100, 64'h0);
        expect_v("irmovq_dstE", 64'h3);     check({60'h0, dstE});
        expect_v("irmovq_srcA", 64'hF);     check({60'h0, srcA});
        expect_v("irmovq_dstM", 64'hF);     check({60'h0, dstM});
        tick();
        read_a(4'h3);
        expect_v("irmovq_valA", 64'h100);   check(valA);
        expect_v("irmovq_retired", 64'h1);  check(retired);

        // popq %rsp: both ports target 0x4, valM wins.
        drive(4'hB, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0, 64'h80, 64'h55);
        expect_v("popq_srcA", 64'h4);       check({60'h0, srcA});
        expect_v("popq_srcB", 64'h4);       check({60'h0, srcB});
        expect_v("popq_dstE", 64'h4);       check({60'h0, dstE});
        expect_v("popq_dstM", 64'h4);       check({60'h0, dstM});
`ifdef WB_BYPASS_EN
        expect_v("popq_pre_valA", 64'h55);  check(valA);
`else
        expect_v("popq_pre_valA", 64'h0);   check(valA);
`endif
        tick();
        read_a(4'h4);
        expect_v("popq_rsp", 64'h55);       check(valA);
        expect_v("popq_retired", 64'h2);    check(retired);

        // cmovXX with cnd=0: no write, still retires.
        drive(4'h2, 4'h1, 4'h3, 1'b1, 1'b0, 1'b0, 64'h7, 64'h0);
        expect_v("cmov0_dstE", 64'hF);      check({60'h0, dstE});
        expect_v("cmov0_srcA", 64'h1);      check({60'h0, srcA});
        tick();
        read_a(4'h3);
        expect_v("cmov0_rbx", 64'h100);     check(valA);
        expect_v("cmov0_retired", 64'h3);   check(retired);

        // cmovXX with cnd=1 writes rB.
        drive(4'h2, 4'h1, 4'h5, 1'b1, 1'b0, 1'b1, 64'h77, 64'h0);
        expect_v("cmov1_dstE", 64'h5);      check({60'h0, dstE});
        tick();
        read_a(4'h5);
        expect_v("cmov1_r5", 64'h77);       check(valA);
        expect_v("cmov1_retired", 64'h4);   check(retired);

        // halt blocks write and counter; no bypass either.
        drive(4'h6, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0, 64'h9, 64'h0);
        expect_v("halt_pre_valB", 64'h0);   check(valB);
        tick();
        expect_v("halt_retired", 64'h4);    check(retired);
        read_a(4'h2);
        expect_v("halt_r2", 64'h0);         check(valA);

        // Same-cycle visibility of a pending write.
        drive(4'h6, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 64'h5, 64'h0);
`ifdef WB_BYPASS_EN
        expect_v("byp_pre_valB", 64'h5);    check(valB);
`else
        expect_v("byp_pre_valB", 64'h0);    check(valB);
`endif
        tick();
        drive(4'h6, 4'hF, 4'h2, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        expect_v("byp_post_valB", 64'h5);   check(valB);
        expect_v("byp_retired", 64'h5);     check(retired);
        expect_v("none_read_valA", 64'h0);  check(valA);

        // Unknown icode selects none everywhere; write to 0xF discarded.
        drive(4'hC, 4'h2, 4'h3, 1'b1, 1'b0, 1'b1, 64'hDEAD, 64'hBEEF);
        expect_v("unk_srcA", 64'hF);        check({60'h0, srcA});
        expect_v("unk_srcB", 64'hF);        check({60'h0, srcB});
        expect_v("unk_dstE", 64'hF);        check({60'h0, dstE});
        expect_v("unk_dstM", 64'hF);        check({60'h0, dstM});
        tick();
        drive(4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        expect_v("unk_r2", 64'h5);          check(valA);
        expect_v("unk_r3", 64'h100);        check(valB);
        expect_v("unk_retired", 64'h6);     check(retired);

        // Mid-cycle reset clears immediately.
        drive(4'h3, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0, 64'h600, 64'h0);
        tick();
        read_a(4'h2);
        expect_v("rdx_valA", 64'h600);      check(valA);
        #1 rst_n = 1'b0;
        #1;
        expect_v("midrst_valA", 64'h0);     check(valA);
        expect_v("midrst_retired", 64'h0);  check(retired);
        #1 rst_n = 1'b1;

        // First write after reset release.
        drive(4'h3, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0, 64'h42, 64'h0);
        tick();
        read_a(4'h2);
        expect_v("post_rst_r2", 64'h42);    check(valA);
        expect_v("post_rst_retired", 64'h1); check(retired);

        // mrmovq with valid=0 changes nothing.
        drive(4'h5, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 64'h0, 64'h99);
        expect_v("mrmov_dstM", 64'h2);      check({60'h0, dstM});
        tick();
        read_a(4'h2);
        expect_v("novalid_r2", 64'h42);     check(valA);
        expect_v("novalid_retired", 64'h1); check(retired);

        if (sb.size() != 0) begin
            n_checks++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_wb.md
DECODE_WB -- requirements
Module: decode_wb

Interface
REQ-001 clk  input  1  rising-edge clock; single clock domain.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 icode  input  4  instruction code from fetch.
REQ-004 rA  input  4  register specifier A from fetch (0xF = none).
REQ-005 rB  input  4  register specifier B from fetch (0xF = none).
REQ-006 valid_instr  input  1  fetch reports a valid instruction.
REQ-007 halt  input  1  fetch reports halt or memory error.
REQ-008 cnd  input  1  condition result from execute; gates conditional moves.
REQ-009 valE  input  64  execute result to write back.
REQ-010 valM  input  64  memory result to write back.
REQ-011 srcA, srcB  output  4 each  selected read registers.
REQ-012 dstE, dstM  output  4 each  selected write registers.
REQ-013 valA, valB  output  64 each  register read data.
REQ-014 retired  output  64  count of committed writeback cycles.

Function
REQ-015 The block SHALL hold fifteen 64-bit registers (IDs 0x0-0xE); register 0x4 is %rsp; ID 0xF is "none".
REQ-016 srcA SHALL be rA for icode 2, 4, 6, A; 0x4 for icode 9, B; 0xF otherwise.
REQ-017 srcB SHALL be rB for icode 4, 5, 6; 0x4 for icode 8, 9, A, B; 0xF otherwise.
REQ-018 dstE SHALL be rB for icode 3 and 6, and for icode 2 only when cnd=1; 0x4 for icode 8, 9, A, B; 0xF otherwise.
REQ-019 dstM SHALL be rA for icode 5 and B; 0xF otherwise.
REQ-020 srcA, srcB, dstE, dstM, valA and valB SHALL be combinational with zero latency from the inputs and the register state.
REQ-021 A read of ID 0xF SHALL return 64'h0.
REQ-022 Write enable (wb_ok) SHALL be valid_instr=1 AND halt=0.
REQ-023 On each rising clk edge with wb_ok=1, the block SHALL write valE to dstE and valM to dstM.
REQ-024 A write to ID 0xF SHALL be discarded.
REQ-025 When dstE equals dstM and the ID is not 0xF, valM SHALL win.
REQ-026 retired SHALL increment by 1 on each edge with wb_ok=1.
REQ-027 retired SHALL wrap from 2^64-1 to 0.
REQ-028 With wb_ok=0, no register and no counter SHALL change.
REQ-029 Unknown icode values SHALL select 0xF for all four selectors, making the instruction a no-op.

Reset
REQ-030 While rst_n=0, all registers and retired SHALL be 0, so valA=valB=0.
REQ-031 Selectors SHALL remain combinational during reset.
REQ-032 An rst_n assertion mid-cycle SHALL clear state immediately, independent of clk.
REQ-033 The first write SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-034 With WB_BYPASS_EN defined, a read register (srcA or srcB) equal to a pending write register with wb_ok=1 SHALL return the pending write data in the same cycle, with valM priority per REQ-025.
REQ-035 Without WB_BYPASS_EN, reads SHALL return the stored value, with new data visible only after the edge.

Structure
REQ-036 Shared package y86_pkg SHALL hold the icode constants (IHALT..IPOPQ), REG_RSP=4'h4 and REG_NONE=4'hF.
REQ-037 Sub-module regfile (2 read ports, 2 write ports, async reset, M-over-E priority) SHALL be instantiated once.
REQ-038 Selection logic and the retired counter SHALL live in decode_wb.

Verification
REQ-039 Reset, then icode=3, rB=3, valE=0x100, valid -> after the edge, a read with rA=3, icode=6 gives valA=0x100 and retired=1.
REQ-040 icode=B (popq), rA=4, valE=0x80, valM=0x55 -> %rsp=0x55 after the edge (M wins).
REQ-041 icode=2, rA=1, rB=3, cnd=0, valE=0x7 -> %rbx unchanged and retired still increments.
REQ-042 halt=1 with icode=6, rB=2, valE=0x9 -> no write and retired unchanged.
REQ-043 Write 0x600 to %rdx, then pulse rst_n low mid-cycle -> valA=0 immediately and retired=0.
REQ-044 With WB_BYPASS_EN, icode=6, rA=2, rB=2, valE=0x5 -> valB=0x5 before the edge; without the macro, valB keeps the old value.
